pointer_bank: RTL and testbench

Parametrised multi-pointer register bank, the successor of the two-pointer IP/DP pair. It holds NPTR pointers of WIDTH bits behind a logical-to-physical role map. Logical pointer 0 is the instruction pointer and is the only one that counts, up or down. An exchange operation swaps any logical pointer with logical pointer 0 in a single cycle, which generalises the old selector bit. Pointers are loaded and read back byte-wise from the 8-bit data bus, and any pointer can be driven onto the tri-state address bus.

---
 rtl/ptr_pkg.sv | 15 +
 rtl/ptr_reg.sv | 39 +++
 rtl/pointer_bank.sv | 95 +++++++++
 tb/tb_pointer_bank.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ptr_pkg.sv
// Shared constants and helpers for the pointer bank and its per-pointer registers.
// Byte width, count-direction encodings and the byte-lane decode live here.
package ptr_pkg;

    localparam int   BYTE_W     = 8;
    localparam int   MAX_LANES  = 4;
    localparam logic COUNT_UP   = 1'b0;
    localparam logic COUNT_DOWN = 1'b1;

    // One-hot lane decode; callers truncate to their own lane count.
    function automatic logic [MAX_LANES-1:0] lane_mask(input logic [1:0] lane);
        return MAX_LANES'(1) << lane;
    endfunction

endpackage

// File: rtl/ptr_reg.sv
// One physical pointer: byte-lane loadable, up/down counting register.
// carry reports that the next count in the current direction wraps.
module ptr_reg
    import ptr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH/BYTE_W-1:0]  lane_we,
    input  logic [BYTE_W-1:0]        di,
    input  logic                     cnt_en,
    input  logic                     dir,
    output logic [WIDTH-1:0]         q,
    output logic                     carry
);

    localparam int NLANES = WIDTH / BYTE_W;

    logic [WIDTH-1:0] q_next;

    assign q_next = (dir == COUNT_DOWN) ? q - WIDTH'(1) : q + WIDTH'(1);
    assign carry  = (dir == COUNT_DOWN) ? (q == '0) : (q == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            // NOTE: non-blocking assignments to the same bits resolve last-wins,
            // so a lane write below overrides the count for that lane.
            if (cnt_en)
                q <= q_next;
            for (int l = 0; l < NLANES; l++)
                if (lane_we[l])
                    q[l*BYTE_W +: BYTE_W] <= di;
        end
    end

endmodule

// File: rtl/pointer_bank.sv
// Multi-pointer register bank behind a logical-to-physical role map.
// Logical pointer 0 counts; any logical pointer can be exchanged with it.
module pointer_bank
    import ptr_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NPTR   = 4,
    parameter int IDX_W  = $clog2(NPTR),
    parameter int LANE_W = (WIDTH / 8 > 1) ? $clog2(WIDTH / 8) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        di,
    input  logic [IDX_W-1:0]  wsel,
    input  logic [LANE_W-1:0] wlane,
    input  logic              n_we,
    input  logic              n_oe_d,
    output logic [7:0]        data_out,
    input  logic [IDX_W-1:0]  asel,
    input  logic              n_oe_addr,
    output logic [WIDTH-1:0]  addr_out,
    input  logic              cnt,
    input  logic              dir,
    input  logic              xchg,
    input  logic [IDX_W-1:0]  xsel,
    output logic              wrap
);

    localparam int NLANES = WIDTH / BYTE_W;

    logic [IDX_W-1:0]  map     [NPTR];
    logic [WIDTH-1:0]  p       [NPTR];
    logic [NLANES-1:0] lane_we [NPTR];
    logic [NPTR-1:0]   cnt_en;
    logic [NPTR-1:0]   carry;
    logic [NLANES-1:0] wmask;
    logic [IDX_W-1:0]  w_phys;
    logic [IDX_W-1:0]  c_phys;
    logic [WIDTH-1:0]  rd_word;
    logic              count_ok;

    // All of this cycle's actions resolve through the map as it stood before the edge.
    assign w_phys   = map[wsel];
    assign c_phys   = map[0];
    assign wmask    = NLANES'(lane_mask(2'(wlane)));
    assign count_ok = cnt && !(!n_we && (w_phys == c_phys));

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        cnt_en = '0;
        for (int i = 0; i < NPTR; i++) begin
            lane_we[i] = '0;
            if (!n_we && (w_phys == IDX_W'(i)))
                lane_we[i] = wmask;
            if (count_ok && (c_phys == IDX_W'(i)))
                cnt_en[i] = 1'b1;
        end
    end

    for (genvar i = 0; i < NPTR; i++) begin : g_ptr
        ptr_reg #(.WIDTH(WIDTH)) u_reg (
            .clk     (clk),
            .rst     (rst),
            .lane_we (lane_we[i]),
            .di      (di),
            .cnt_en  (cnt_en[i]),
            .dir     (dir),
            .q       (p[i]),
            .carry   (carry[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the map is a few flops rather than a RAM, so it is reset like any register.
            for (int i = 0; i < NPTR; i++)
                map[i] <= IDX_W'(i);
        end else if (xchg) begin
            map[0]    <= map[xsel];
            map[xsel] <= map[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wrap <= 1'b0;
        else if (count_ok)
            wrap <= carry[c_phys];
    end

    assign rd_word  = p[map[wsel]];
    assign addr_out = n_oe_addr ? 'z : p[map[asel]];
    assign data_out = n_oe_d ? 'z : BYTE_W'(rd_word >> (wlane * BYTE_W));

endmodule

// File: tb/tb_pointer_bank.sv
// Randomised and directed bench for pointer_bank (WIDTH=16, NPTR=4) with a scoreboard.
// The model tracks logical pointer values directly; exchanges swap values, not indices.
module tb_pointer_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  di = '0;
    logic [1:0]  wsel = '0;
    logic        wlane = 1'b0;
    logic        n_we = 1'b1;
    logic        n_oe_d = 1'b1;
    wire  [7:0]  data_out;
    logic [1:0]  asel = '0;
    logic        n_oe_addr = 1'b1;
    wire  [15:0] addr_out;
    logic        cnt = 1'b0;
    logic        dir = 1'b0;
    logic        xchg = 1'b0;
    logic [1:0]  xsel = '0;
    wire         wrap;

    pointer_bank #(.WIDTH(16), .NPTR(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .di        (di),
        .wsel      (wsel),
        .wlane     (wlane),
        .n_we      (n_we),
        .n_oe_d    (n_oe_d),
        .data_out  (data_out),
        .asel      (asel),
        .n_oe_addr (n_oe_addr),
        .addr_out  (addr_out),
        .cnt       (cnt),
        .dir       (dir),
        .xchg      (xchg),
        .xsel      (xsel),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    typedef enum int { K_ADDR, K_DATA, K_WRAP } kind_t;
    typedef struct {
        string       name;
        kind_t       kind;
        logic [15:0] exp;
    } rec_t;

    rec_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] lp [4];
    logic        wrap_m;

    function automatic void push(input string n, input kind_t k, input logic [15:0] e);
        rec_t r;
        r.name = n;
        r.kind = k;
        r.exp  = e;
        exp_q.push_back(r);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) lp[i] = 16'h0000;
        wrap_m = 1'b0;
    endfunction

    task automatic check(input rec_t r);
        logic [15:0] act;
        case (r.kind)
            K_ADDR:  act = addr_out;
            K_DATA:  act = {8'h00, data_out};
            default: act = {15'h0000, wrap};
        endcase
        vectors++;
        if (act !== r.exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", r.name, act, r.exp);
        end
    endtask

    // Monitor: whatever the driver expects of the current cycle is compared mid-cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) check(exp_q.pop_front());
    end

    // One clock of stimulus: drive, predict reads from the pre-edge model, then advance the model.
    task automatic step(input logic we, input logic [1:0] ws, input logic lw, input logic [7:0] d,
                        input logic c, input logic dr, input logic x, input logic [1:0] xs,
                        input logic [1:0] as, input logic oa, input logic od, input string tag);
        logic [15:0] old0;
        logic        wrote0;
        logic [15:0] t;
        n_we = ~we; wsel = ws; wlane = lw; di = d;
        cnt = c; dir = dr; xchg = x; xsel = xs;
        asel = as; n_oe_addr = ~oa; n_oe_d = ~od;
        push({tag, "_addr"}, K_ADDR, oa ? lp[as] : 16'hzzzz);
        push({tag, "_data"}, K_DATA, od ? {8'h00, lp[ws][lw*8 +: 8]} : {8'h00, 8'hzz});
        push({tag, "_wrap"}, K_WRAP, {15'h0000, wrap_m});
        @(posedge clk);
        #1;
        old0   = lp[0];
        wrote0 = we && (ws == 2'd0);
        if (we) lp[ws][lw*8 +: 8] = d;
        if (c && !wrote0) begin
            lp[0]  = dr ? old0 - 16'd1 : old0 + 16'd1;
            wrap_m = dr ? (old0 == 16'h0000) : (old0 == 16'hFFFF);
        end
        if (x) begin
            t      = lp[0];
            lp[0]  = lp[xs];
            lp[xs] = t;
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state: buses released, then every pointer reads zero.
        step(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, "rst_z");
        for (int a = 0; a < 4; a++)
            step(0, 0, 0, 8'h00, 0, 0, 0, 0, 2'(a), 1, 0, "rst_ptr");

        // Byte load of pointer 2, then address and byte read-back.
        step(1, 2, 0, 8'hFE, 0, 0, 0, 0, 2, 1, 0, "load_lo");
        step(1, 2, 1, 8'h12, 0, 0, 0, 0, 2, 1, 0, "load_hi");
        step(0, 2, 0, 8'h00, 0, 0, 0, 0, 2, 1, 1, "rd_lane0");
        step(0, 2, 1, 8'h00, 0, 0, 0, 0, 2, 1, 1, "rd_lane1");

        // Count through the up and down wrap points.
        step(1, 0, 0, 8'hFE, 0, 0, 0, 0, 0, 1, 0, "p0_lo");
        step(1, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 1, 0, "p0_hi");
        step(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, "up_fffe");
        step(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, "up_ffff");
        step(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, "up_0000");
        step(0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 0, "dn_0001");
        step(0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 0, "dn_0000");
        step(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, "dn_ffff");

        // Exchange pointer 0 with pointer 2, count, then swap back.
        step(1, 0, 0, 8'h02, 0, 0, 0, 0, 0, 1, 0, "x_lo");
        step(1, 0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 0, "x_hi");
        step(0, 0, 0, 8'h00, 0, 0, 1, 2, 0, 1, 0, "xchg1");
        step(0, 0, 0, 8'h00, 0, 0, 0, 0, 2, 1, 0, "x_as2");
        step(0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, "x_cnt");
        step(0, 0, 0, 8'h00, 0, 0, 1, 2, 0, 1, 0, "xchg2");
        step(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, "x_back0");
        step(0, 0, 0, 8'h00, 0, 0, 0, 0, 2, 1, 0, "x_back2");

        // Write/count collision on the same pointer, then on different pointers.
        step(1, 0, 0, 8'hFE, 0, 0, 0, 0, 0, 1, 0, "c_lo");
        step(1, 0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 0, "c_hi");
        step(1, 0, 0, 8'h55, 1, 0, 0, 0, 0, 1, 0, "coll_same");
        step(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, "coll_res");
        step(1, 0, 0, 8'hFE, 0, 0, 0, 0, 0, 1, 0, "c_reload");
        step(1, 1, 0, 8'h55, 1, 0, 0, 0, 0, 1, 0, "coll_diff");
        step(0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1, "coll_res2");

        // Asynchronous reset pulse between edges with count and exchange pending.
        step(1, 3, 1, 8'hC3, 0, 0, 0, 0, 3, 1, 0, "pre_rst");
        cnt = 1'b1; xchg = 1'b1; xsel = 2'd2; n_we = 1'b1;
        asel = 2'd3; n_oe_addr = 1'b0; n_oe_d = 1'b1;
        #1 rst = 1'b1;
        model_reset();
        push("async_rst_addr", K_ADDR, 16'h0000);
        push("async_rst_wrap", K_WRAP, 16'h0000);
        #4;
        rst = 1'b0; cnt = 1'b0; xchg = 1'b0;
        @(posedge clk);
        #1;
        step(1, 2, 0, 8'hA5, 0, 0, 0, 0, 0, 1, 0, "post_rst_wr");
        step(0, 0, 0, 8'h00, 1, 0, 0, 0, 2, 1, 0, "post_rst_cnt");
        step(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, "post_rst_p0");
        step(0, 0, 0, 8'h00, 0, 0, 0, 0, 2, 1, 0, "post_rst_p2");

        // Random traffic, with the read buses toggling on and off.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 2) == 0), 2'($urandom), 1'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 2'($urandom),
                 2'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom), "rand");
        end

        n_we = 1'b1; cnt = 1'b0; xchg = 1'b0;
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
